// File: rtl/idct8_pkg.sv
// Shared constants, defaults and FSM state type for the 8-point serial IDCT.
package idct8_pkg;
  localparam int IN_W_DEF  = 18;
  localparam int OUT_W_DEF = 9;
  localparam int SHIFT_DEF = 15;

  localparam int C64 = 64;
  localparam int C83 = 83;
  localparam int C36 = 36;
  localparam int C89 = 89;
  localparam int C75 = 75;
  localparam int C50 = 50;
  localparam int C18 = 18;

  typedef enum logic [1:0] {
    LOAD,
    CALC,
    DRAIN
  } state_t;
endpackage

// File: rtl/idct4_even.sv
// Even half of the 8-point IDCT: E[0..3] from Y0, Y2, Y4, Y6 (shift-add only).
module idct4_even
  import idct8_pkg::*;
#(
  parameter int IN_W = IN_W_DEF,
  parameter int W    = IN_W + 10
) (
  input  logic signed [IN_W-1:0] y0,
  input  logic signed [IN_W-1:0] y2,
  input  logic signed [IN_W-1:0] y4,
  input  logic signed [IN_W-1:0] y6,
  output logic signed [W-1:0]    e [4]
);

  // constant c expands to a sum of shifted copies, no multiplier
  function automatic logic signed [W-1:0] cmul(
    input logic signed [IN_W-1:0] a,
    input int                     c
  );
    logic signed [W-1:0] ax;
    logic signed [W-1:0] r;
    ax = W'(a);
    r  = '0;
    for (int i = 0; i < 8; i++)
      if (c[i]) r = r + (ax <<< i);
    return r;
  endfunction

  logic signed [W-1:0] ee0, ee1, eo0, eo1;

  always_comb begin
    ee0  = cmul(y0, C64) + cmul(y4, C64);
    ee1  = cmul(y0, C64) - cmul(y4, C64);
    eo0  = cmul(y2, C83) + cmul(y6, C36);
    eo1  = cmul(y2, C36) - cmul(y6, C83);
    e[0] = ee0 + eo0;
    e[1] = ee1 + eo1;
    e[2] = ee1 - eo1;
    e[3] = ee0 - eo0;
  end

endmodule

// File: rtl/idct8_serial.sv
// Serial 8-point integer IDCT: load 8 coefficients, compute, drain 8 samples.
// Define IDCT8_SAT_EN to saturate outputs instead of wrapping.
module idct8_serial
  import idct8_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_last
);

  localparam int W = IN_W + 10;
  localparam logic signed [W-1:0] RND = W'(2 ** (SHIFT - 1));
  localparam logic signed [W-1:0] HI  = W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [W-1:0] LO  = ~HI;

  state_t state, state_n;
  logic [2:0] cnt;
  logic signed [IN_W-1:0]  coef [8];
  logic signed [OUT_W-1:0] obuf [8];
  logic signed [W-1:0] e [4];
  logic signed [W-1:0] o [4];
  logic signed [W-1:0] x [8];
  logic in_fire, out_fire;

  function automatic logic signed [W-1:0] cmul(
    input logic signed [IN_W-1:0] a,
    input int                     c
  );
    logic signed [W-1:0] ax;
    logic signed [W-1:0] r;
    ax = W'(a);
    r  = '0;
    for (int i = 0; i < 8; i++)
      if (c[i]) r = r + (ax <<< i);
    return r;
  endfunction

  function automatic logic signed [OUT_W-1:0] rnd(
    input logic signed [W-1:0] v
  );
    logic signed [W-1:0] q;
    q = (v + RND) >>> SHIFT;
`ifdef IDCT8_SAT_EN
    if (q > HI) return OUT_W'(HI);
    if (q < LO) return OUT_W'(LO);
`endif
    return OUT_W'(q);
  endfunction

  idct4_even #(
    .IN_W (IN_W),
    .W    (W)
  ) u_even (
    .y0 (coef[0]),
    .y2 (coef[2]),
    .y4 (coef[4]),
    .y6 (coef[6]),
    .e  (e)
  );

  always_comb begin
    o[0] = cmul(coef[1], C89) + cmul(coef[3], C75)
         + cmul(coef[5], C50) + cmul(coef[7], C18);
    o[1] = cmul(coef[1], C75) - cmul(coef[3], C18)
         - cmul(coef[5], C89) - cmul(coef[7], C50);
    o[2] = cmul(coef[1], C50) - cmul(coef[3], C89)
         + cmul(coef[5], C18) + cmul(coef[7], C75);
    o[3] = cmul(coef[1], C18) - cmul(coef[3], C50)
         + cmul(coef[5], C75) - cmul(coef[7], C89);
    for (int n = 0; n < 4; n++) begin
      x[n]     = e[n] + o[n];
      x[7 - n] = e[n] - o[n];
    end
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && cnt == 3'd7) state_n = CALC;
      end
      CALC: state_n = DRAIN;
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && cnt == 3'd7) state_n = LOAD;
      end
      default: state_n = LOAD;
    endcase
  end

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign out_data = out_valid ? obuf[cnt] : '0;
  assign out_last = out_valid && cnt == 3'd7;

  // one counter serves both phases; it wraps to 0 on the 8th beat
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (in_fire || out_fire) cnt <= cnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) coef[cnt] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (state == CALC)
      for (int n = 0; n < 8; n++) obuf[n] <= rnd(x[n]);
  end

endmodule

// File: tb/tb_idct8_serial.sv
// Randomized bench for idct8_serial against a matrix-form IDCT model.
// Honours IDCT8_SAT_EN the same way as the design.
module tb_idct8_serial;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [17:0] in_data = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic signed [8:0] out_data;
  logic out_last;

  idct8_serial dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int T [8][8] = '{
    '{64,  64,  64,  64,  64,  64,  64,  64},
    '{89,  75,  50,  18, -18, -50, -75, -89},
    '{83,  36, -36, -83, -83, -36,  36,  83},
    '{75, -18, -89, -50,  50,  89,  18, -75},
    '{64, -64, -64,  64,  64, -64, -64,  64},
    '{50, -89,  18,  75, -75, -18,  89, -50},
    '{36, -83,  83, -36, -36,  83, -83,  36},
    '{18, -50,  75, -89,  89, -75,  50, -18}
  };

  typedef struct {
    int d;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   got[$];
  int   pos = 0;
  int   rdy_mode = 0;

  task automatic check(input string nm, input longint g, input longint e);
    n_cmp++;
    if (g != e) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, g, e);
    end
  endtask

  function automatic int model(input int y[8], input int n);
    longint acc;
    longint r;
    acc = 0;
    for (int k = 0; k < 8; k++) acc += longint'(T[k][n]) * y[k];
    r = (acc + 16384) >>> 15;
`ifdef IDCT8_SAT_EN
    if (r > 255) r = 255;
    if (r < -256) r = -256;
`else
    r = r & 511;
    if (r > 255) r -= 512;
`endif
    return int'(r);
  endfunction

  task automatic fwd(input int xs[8], output int y[8]);
    for (int k = 0; k < 8; k++) begin
      y[k] = 0;
      for (int n = 0; n < 8; n++) y[k] += T[k][n] * xs[n];
    end
  endtask

  task automatic send_block(input int y[8], input int nb, input bit gaps);
    int  k;
    int  guard;
    bit  hs;
    exp_t e;
    k = 0;
    guard = 0;
    while (k < nb) begin
      @(negedge clk);
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = in_valid ? 18'(y[k]) : 18'($urandom);
      hs = in_valid && in_ready;
      @(posedge clk);
      if (hs) k++;
      guard++;
      if (guard > 500) begin
        check("load_timeout", k, nb);
        break;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (nb == 8)
      for (int n = 0; n < 8; n++) begin
        e.d = model(y, n);
        e.last = (n == 7);
        exp_q.push_back(e);
      end
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 || out_valid) begin
      @(negedge clk);
      guard++;
      if (guard > 300) begin
        check("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
        break;
      end
    end
  endtask

  task automatic wait_pos(input int p);
    int guard;
    guard = 0;
    do begin
      @(posedge clk);
      #3;
      guard++;
    end while (!(out_valid && pos == p) && guard < 200);
    if (guard >= 200) check("wait_pos_timeout", pos, p);
  endtask

  always @(posedge clk) begin
    #2;
    if (rdy_mode == 0) out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
  end

  logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic signed [8:0] pd = '0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      pv  = 1'b0;
      pos = 0;
    end else begin
      if (out_valid) begin
        check("no_overlap", in_ready, 0);
        if (pv && !pr) begin
          check("hold_data", out_data, pd);
          check("hold_last", out_last, pl);
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("data", out_data, e.d);
            check("last", out_last, e.last);
            got.push_back(int'(out_data));
            pos = (pos + 1) % 8;
          end
        end
      end
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
      pl = out_last;
    end
  end

  initial begin
    int dc[8];
    int ov[8];
    int xs[8];
    int y[8];
    int hold;

    dc = '{5120, 0, 0, 0, 0, 0, 0, 0};
    ov = '{131071, 0, 0, 0, 0, 0, 0, 0};
    xs = '{0, 1, 2, 3, 4, 5, 6, 7};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    rst = 1'b0;

    check("model_dc0", model(dc, 0), 10);
    check("model_dc7", model(dc, 7), 10);
`ifdef IDCT8_SAT_EN
    check("model_ovf", model(ov, 3), 255);
`else
    check("model_ovf", model(ov, 3), -256);
`endif

    // DC block with latency check
    got.delete();
    send_block(dc, 8, 1'b0);
    check("lat_calc", out_valid, 0);
    @(negedge clk);
    check("lat_first", out_valid, 1);
    wait_drain();
    check("dc_count", got.size(), 8);

    // round trip
    got.delete();
    fwd(xs, y);
    send_block(y, 8, 1'b1);
    wait_drain();
    check("rt_count", got.size(), 8);
    for (int n = 0; n < 8 && n < got.size(); n++) begin
      hold = got[n] - xs[n];
      check("rt_within1", (hold >= -1 && hold <= 1), 1);
    end

    // overflow
    send_block(ov, 8, 1'b0);
    wait_drain();

    // backpressure at n=2, with ignored in_valid during the stall
    rdy_mode = 3;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) y[k] = $urandom_range(0, 8191) - 4096;
    send_block(y, 8, 1'b0);
    wait_pos(2);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 18'($urandom);
    hold = model(y, 2);
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_data", out_data, hold);
      check("bp_last", out_last, 0);
    end
    @(posedge clk);
    #3;
    out_ready = 1'b1;
    in_valid = 1'b0;
    wait_drain();

    // reset mid-drain at n=4
    for (int k = 0; k < 8; k++) y[k] = $urandom_range(0, 8191) - 4096;
    send_block(y, 8, 1'b0);
    wait_pos(4);
    out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rd_out_valid", out_valid, 0);
    check("rd_in_ready", in_ready, 1);
    check("rd_out_data", out_data, 0);
    rst = 1'b0;
    exp_q.delete();
    rdy_mode = 0;
    send_block(dc, 8, 1'b0);
    wait_drain();

    // reset mid-load, then a full block
    send_block(ov, 3, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_block(xs, 8, 1'b0);
    wait_drain();

    // same block gap-free then gappy
    for (int k = 0; k < 8; k++) y[k] = $urandom_range(0, 262143) - 131072;
    send_block(y, 8, 1'b0);
    wait_drain();
    send_block(y, 8, 1'b1);
    wait_drain();

    // extreme magnitude block targeting x[0]
    for (int k = 0; k < 8; k++) y[k] = (T[k][0] < 0) ? -131072 : 131071;
    send_block(y, 8, 1'b1);
    wait_drain();

    // randomized blocks with random backpressure and gaps
    rdy_mode = 1;
    for (int b = 0; b < 30; b++) begin
      for (int k = 0; k < 8; k++)
        y[k] = (b % 2 == 0) ? $urandom_range(0, 262143) - 131072
                            : $urandom_range(0, 4095) - 2048;
      send_block(y, 8, 1'($urandom_range(0, 1)));
      wait_drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/idct8_serial.md
IDCT8_SERIAL -- requirements
Module: idct8_serial

Interface
REQ-001 Parameter IN_W, default 18, signed coefficient width (matches forward 8-bit DCT output width).
REQ-002 Parameter OUT_W, default 9, signed reconstructed sample width.
REQ-003 Parameter SHIFT, default 15, final rounding right-shift (forward x inverse gain is 2^15).
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset; synchronous and active-high.
REQ-006 in_valid  in  1  coefficient beat valid.
REQ-007 in_ready  out  1  block can accept a coefficient.
REQ-008 in_data  in  IN_W  signed coefficient Y[k], k=0..7 in ascending order.
REQ-009 out_valid  out  1  sample beat valid.
REQ-010 out_ready  in  1  downstream accepts sample.
REQ-011 out_data  out  OUT_W  signed sample x[n], n=0..7 in ascending order.
REQ-012 out_last  out  1  high with out_valid on beat n=7 only.

Function
REQ-013 Block shall be a three-state FSM: LOAD, CALC, DRAIN.
REQ-014 LOAD: in_ready=1, out_valid=0; each in_valid&&in_ready handshake stores in_data into coefficient slot k and increments a 3-bit beat counter.
REQ-015 Handshake on beat k=7 shall transition to CALC and clear the counter; no other event leaves LOAD.
REQ-016 CALC: exactly one cycle, in_ready=0, out_valid=0; all eight results registered into the output buffer; then DRAIN.
REQ-017 Arithmetic: even part E[0..3] from Y0,Y2,Y4,Y6 with coefficients 64/83/36; odd part O[0..3] from Y1,Y3,Y5,Y7 with 89/75/50/18 (transpose of the forward basis); x[n]=E[n]+O[n], x[7-n]=E[n]-O[n], n=0..3.
REQ-018 Multiplies shall be shift-add only; no multiplier primitives.
REQ-019 Internal width shall be IN_W+10 bits signed; no intermediate overflow for any input.
REQ-020 Rounding: add 2^(SHIFT-1), then arithmetic right shift by SHIFT (floor).
REQ-021 DRAIN: out_valid=1, out_data=x[n] for current n; n advances only on out_valid&&out_ready.
REQ-022 While out_ready=0, out_data and out_last shall hold stable.
REQ-023 Handshake on n=7 shall transition to LOAD; in_ready rises the following cycle (no input/output overlap).
REQ-024 Latency: first out_valid is asserted 2 cycles after the clock edge accepting Y[7].
REQ-025 in_valid while in_ready=0 shall be ignored and shall not corrupt stored data.

Reset
REQ-026 rst=1 at any clock edge shall force LOAD, beat counters=0, in_ready=1 after reset, out_valid=0, out_last=0, out_data=0.
REQ-027 Reset mid-LOAD or mid-DRAIN shall discard the partial block; next accepted beat is Y[0].
REQ-028 Coefficient storage need not be cleared by reset.

Configuration
REQ-029 Macro IDCT8_SAT_EN: when defined, rounded result shall be saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-030 Without IDCT8_SAT_EN, result shall be truncated to the low OUT_W bits (two's-complement wrap).

Structure
REQ-031 Package idct8_pkg shall hold basis constants (64,83,36,89,75,50,18), the FSM state enum, and the default width/shift values.
REQ-032 Even part shall be a combinational sub-module idct4_even (4 coefficients in, E[0..3] out); odd part and butterfly stay in idct8_serial.

Verification
REQ-033 DC: Y={5120,0,0,0,0,0,0,0}, out_ready=1 -> x[n]=10 for all n, out_last on 8th beat, first out_valid 2 cycles after Y[7].
REQ-034 Round trip: forward DCT of x={0,1,2,3,4,5,6,7} fed in -> output equals input within +/-1 per sample.
REQ-035 Overflow: Y={131071,0,...,0} -> 255 on all beats with IDCT8_SAT_EN; -256 without.
REQ-036 Backpressure: out_ready=0 for 3 cycles at n=2 -> out_data/out_last held, n=3 follows on release, in_ready stays 0 until DRAIN ends.
REQ-037 Reset mid-DRAIN at n=4 -> out_valid=0 next cycle, in_ready=1; following full block decodes correctly.
REQ-038 in_valid toggled randomly with gaps during LOAD -> results identical to gap-free run.
